// File: rtl/min_pca_pkg.sv
// Shared types and defaults for the minor-component PCA scorer.
// Feature macro used by the datapath: MIN_PCA_SCORE_SAT_EN (saturating term/accumulator).
package min_pca_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } min_pca_state_t;

    localparam int DEF_PC_NUM = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_INV_W  = 32;
    localparam int DEF_FRAC_W = 16;
    localparam int DEF_ACC_W  = 48;

    // pc^2 carries 2*FRAC fraction bits; multiplying by 1/lambda adds FRAC more, and the
    // score keeps FRAC, so 2*FRAC bits are dropped from the product.
    function automatic int q_shift(input int frac_w);
        return 2 * frac_w;
    endfunction

endpackage

// File: rtl/min_pca_term.sv
// Two-stage pc^2 * (1/lambda) pipeline with valid/last sidebands and ACC_W reduction.
// MIN_PCA_SCORE_SAT_EN: saturate the reduced term instead of truncating its upper bits.
module min_pca_term
    import min_pca_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int INV_W  = DEF_INV_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beat_valid,
    input  logic              beat_last,
    input  logic [DATA_W-1:0] beat_pc,
    input  logic [INV_W-1:0]  beat_inv,
    output logic              term_valid,
    output logic              term_last,
    output logic [ACC_W-1:0]  term,
    output logic              term_ovf
);

    localparam int SQ_W   = 2 * DATA_W;
    localparam int PROD_W = SQ_W + INV_W;
    localparam int SHIFT  = q_shift(FRAC_W);

    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q,  s1_last_d;
    logic [SQ_W-1:0]   s1_sq_q,    s1_sq_d;
    logic [INV_W-1:0]  s1_inv_q,   s1_inv_d;
    logic              s2_valid_q, s2_valid_d;
    logic              s2_last_q,  s2_last_d;
    logic [PROD_W-1:0] s2_prod_q,  s2_prod_d;

    logic [SQ_W-1:0]   pc_ext;
    logic [PROD_W-1:0] shifted;
    logic              upper_nz;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        s1_valid_d = beat_valid;
        s1_last_d  = s1_last_q;
        s1_sq_d    = s1_sq_q;
        s1_inv_d   = s1_inv_q;
        s2_valid_d = s1_valid_q;
        s2_last_d  = s2_last_q;
        s2_prod_d  = s2_prod_q;

        // Sign-extended square: low SQ_W bits of the unsigned product equal |pc|^2.
        pc_ext = {{DATA_W{beat_pc[DATA_W-1]}}, beat_pc};
        if (beat_valid) begin
            s1_last_d = beat_last;
            s1_sq_d   = pc_ext * pc_ext;
            s1_inv_d  = beat_inv;
        end
        if (s1_valid_q) begin
            s2_last_d = s1_last_q;
            s2_prod_d = {{INV_W{1'b0}}, s1_sq_q} * {{SQ_W{1'b0}}, s1_inv_q};
        end

        shifted  = s2_prod_q >> SHIFT;
        upper_nz = |shifted[PROD_W-1:ACC_W];
`ifdef MIN_PCA_SCORE_SAT_EN
        term = upper_nz ? {ACC_W{1'b1}} : shifted[ACC_W-1:0];
`else
        term = shifted[ACC_W-1:0];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sq_q    <= '0;
            s1_inv_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_sq_q    <= s1_sq_d;
            s1_inv_q   <= s1_inv_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_prod_q  <= s2_prod_d;
        end
    end

    assign term_valid = s2_valid_q;
    assign term_last  = s2_last_q;
    assign term_ovf   = upper_nz;

endmodule

// File: rtl/min_pca_score_stream.sv
// Streaming minor-component PCA scorer: accumulates pc^2/lambda per vector, flags alarm/length/overflow.
// MIN_PCA_SCORE_SAT_EN: accumulator saturates at 2^ACC_W-1 instead of wrapping.
module min_pca_score_stream
    import min_pca_pkg::*;
#(
    parameter int PC_NUM = DEF_PC_NUM,
    parameter int DATA_W = DEF_DATA_W,
    parameter int INV_W  = DEF_INV_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [INV_W-1:0]  in_inv_eig,
    input  logic              in_last,
    input  logic [ACC_W-1:0]  threshold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_score,
    output logic              out_alarm,
    output logic              out_len_err,
    output logic              out_ovf
);

    localparam int CNT_W = $clog2(PC_NUM + 1);

    min_pca_state_t   state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] thr_q, thr_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic             len_err_q, len_err_d;
    logic             acc_done_q, acc_done_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_score_q, out_score_d;
    logic             out_alarm_q, out_alarm_d;
    logic             out_len_err_q, out_len_err_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept, at_limit, end_beat;
    logic [CNT_W-1:0] beat_idx;
    logic [ACC_W:0]   sum;
    logic             term_valid, term_last, term_ovf;
    logic [ACC_W-1:0] term;

    min_pca_term #(
        .DATA_W(DATA_W),
        .INV_W (INV_W),
        .FRAC_W(FRAC_W),
        .ACC_W (ACC_W)
    ) u_term (
        .clk       (clk),
        .reset     (reset),
        .beat_valid(accept),
        .beat_last (end_beat),
        .beat_pc   (in_pc),
        .beat_inv  (in_inv_eig),
        .term_valid(term_valid),
        .term_last (term_last),
        .term      (term),
        .term_ovf  (term_ovf)
    );

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        thr_d         = thr_q;
        acc_d         = acc_q;
        acc_ovf_d     = acc_ovf_q;
        len_err_d     = len_err_q;
        acc_done_d    = acc_done_q;
        out_valid_d   = out_valid_q;
        out_score_d   = out_score_q;
        out_alarm_d   = out_alarm_q;
        out_len_err_d = out_len_err_q;
        out_ovf_d     = out_ovf_q;

        accept   = in_valid && in_ready_q;
        beat_idx = (state_q == ST_IDLE) ? '0 : count_q;
        at_limit = (beat_idx == CNT_W'(PC_NUM - 1));
        end_beat = accept && (in_last || at_limit);

        unique case (state_q)
            ST_IDLE: if (accept) begin
                thr_d      = threshold;
                acc_d      = '0;
                acc_ovf_d  = 1'b0;
                len_err_d  = 1'b0;
                acc_done_d = 1'b0;
                count_d    = CNT_W'(1);
                state_d    = end_beat ? ST_DRAIN : ST_ACCUM;
            end
            ST_ACCUM: if (accept) begin
                count_d = count_q + 1'b1;
                if (end_beat) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (acc_done_q) begin
                state_d       = ST_HOLD;
                acc_done_d    = 1'b0;
                out_valid_d   = 1'b1;
                out_score_d   = acc_q;
                out_alarm_d   = (acc_q > thr_q);
                out_len_err_d = len_err_q;
                out_ovf_d     = acc_ovf_q;
            end
            ST_HOLD: if (out_ready) begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Early in_last or a forced end without in_last both mean the length was wrong.
        if (end_beat) len_err_d = (in_last && !at_limit) || (at_limit && !in_last);

        sum = {1'b0, acc_q} + {1'b0, term};
        if (term_valid) begin
`ifdef MIN_PCA_SCORE_SAT_EN
            acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            acc_ovf_d = acc_ovf_q | sum[ACC_W] | term_ovf;
            if (term_last) acc_done_d = 1'b1;
        end

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b0;
            count_q       <= '0;
            thr_q         <= '0;
            acc_q         <= '0;
            acc_ovf_q     <= 1'b0;
            len_err_q     <= 1'b0;
            acc_done_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_score_q   <= '0;
            out_alarm_q   <= 1'b0;
            out_len_err_q <= 1'b0;
            out_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            count_q       <= count_d;
            thr_q         <= thr_d;
            acc_q         <= acc_d;
            acc_ovf_q     <= acc_ovf_d;
            len_err_q     <= len_err_d;
            acc_done_q    <= acc_done_d;
            out_valid_q   <= out_valid_d;
            out_score_q   <= out_score_d;
            out_alarm_q   <= out_alarm_d;
            out_len_err_q <= out_len_err_d;
            out_ovf_q     <= out_ovf_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_score   = out_score_q;
    assign out_alarm   = out_alarm_q;
    assign out_len_err = out_len_err_q;
    assign out_ovf     = out_ovf_q;

endmodule

// File: doc/min_pca_score_stream.md
# min_pca_score_stream

Clocked, parametrised minor-component PCA scorer for the IDS datapath. It consumes one principal component per beat as a fixed-point value, paired with its precomputed reciprocal eigenvalue. It accumulates the sum of pc² · (1/λ) over `PC_NUM` components, then emits the score with a threshold alarm. It sits between the PC projection stage and the IDS decision logic, and replaces the combinational real-valued scorer with a synthesisable pipelined unit.

## Interface
- `PC_NUM`, 5, number of minor components per vector (≥1)
- `DATA_W`, 32, signed component width
- `INV_W`, 32, unsigned reciprocal-eigenvalue width
- `FRAC_W`, 16, fractional bits shared by component, reciprocal and score
- `ACC_W`, 48, unsigned accumulator/score width
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low reset (the block's one clock is `clk`)
- `in_valid` in 1: component beat valid
- `in_ready` out 1: block accepts a beat
- `in_pc` in `DATA_W`: signed component, Q(DATA_W−FRAC_W).FRAC_W
- `in_inv_eig` in `INV_W`: 1/λ, unsigned Q(INV_W−FRAC_W).FRAC_W
- `in_last` in 1: final component of vector
- `threshold` in `ACC_W`: alarm threshold, same format as score
- `out_valid` out 1: score valid
- `out_ready` in 1: downstream accepts score
- `out_score` out `ACC_W`: accumulated score
- `out_alarm` out 1: `out_score` > captured threshold
- `out_len_err` out 1: vector length ≠ `PC_NUM`
- `out_ovf` out 1: accumulator overflow occurred

## Operation
- FSM has four states: IDLE, ACCUM, DRAIN, HOLD.
- IDLE → ACCUM: first accepted beat. `threshold` is captured on this beat. The accumulator and the count are cleared.
- ACCUM → DRAIN: a beat is accepted with `in_last`=1, or a beat is accepted with count = `PC_NUM`−1 (forced end).
- DRAIN → HOLD: once the last term has entered the accumulator.
- HOLD → IDLE: on `out_valid && out_ready`.
- `in_ready` = 1 in IDLE and ACCUM only.
- Term arithmetic:
  - Stage 1: sq = in_pc², full 2·`DATA_W` unsigned.
  - Stage 2: prod = sq · in_inv_eig, full width.
  - The term is prod >> 2·`FRAC_W`, truncated toward zero, then reduced to `ACC_W`.
- Stage 3: acc += term.
- A reciprocal of 0 yields a 0 term. This is how a component is masked.
- `out_len_err` = 1 in either of these cases:
  - `in_last` arrives with count < `PC_NUM`−1.
  - The forced end fires without `in_last`.
- The score still covers the accepted beats.
- `out_alarm` uses strict greater-than, unsigned.
- Output fields are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- All outputs reset to 0: `in_ready`, `out_valid`, `out_score`, `out_alarm`, `out_len_err`, `out_ovf`. `in_ready` rises on the first clock after reset deasserts.
- Throughput is one beat per cycle within a vector.
- Latency: `out_valid` asserts 3 cycles after the clock edge accepting the last beat.
- There is no overlap between vectors. The next vector is accepted the cycle after the output handshake.
- A beat with `in_valid`=1 while `in_ready`=0 is not consumed. The source must hold it.
- If `reset` is asserted mid-vector or while in HOLD, the pipeline is flushed and the partial score is discarded. No output is produced.
- Pipeline registers advance only on valid data. Bubbles (in_valid=0 in ACCUM) do not disturb the accumulator.

## Configuration
- `MIN_PCA_SCORE_SAT_EN` defined:
  - Term reduction to `ACC_W` and the accumulator add both saturate at 2^`ACC_W`−1.
  - `out_ovf` latches 1 for the vector.
- Undefined:
  - Both wrap modulo 2^`ACC_W`.
  - `out_ovf` still flags any lost carry or truncated upper bits.

## Structure
- A shared package `min_pca_pkg` holds:
  - the FSM state enum `min_pca_state_t`
  - default width constants
  - a function for the Q-format shift amount
- Sub-module `min_pca_term` is the 2-stage pc²·(1/λ) multiplier pipeline, with valid and last sidebands. The top holds the FSM, counter, accumulator and output register.

## Test plan
- Nominal: `PC_NUM`=5, each in_pc=0x00020000 (2.0), in_inv_eig=0x00008000 (0.5), `in_last` on beat 5, threshold=0x90000 (9.0) → out_score=0xA0000 (10.0), alarm=1, len_err=0, ovf=0, `out_valid` at 3 cycles after beat 5.
- Same vector with threshold=0xA0000 → alarm=0 (strict compare).
- Negative and masked: pc=−3.0 (0xFFFD0000), inv=1.0, the other four with inv=0 → score=0x90000 (9.0).
- Length: `in_last` on beat 3 → score over 3 terms, len_err=1. A separate vector with no `in_last` → forced end after beat 5, len_err=1.
- Backpressure and bubbles:
  - Hold `out_ready`=0 for 10 cycles: outputs stay stable and `in_ready`=0.
  - Random `in_valid` gaps: score is unchanged.
- Overflow: pc=0x7FFFFFFF, inv=0xFFFFFFFF, five beats.
  - With the macro: score=2^48−1, ovf=1.
  - Without it: wrapped value, ovf=1.
- Reset pulse mid-vector → no `out_valid`. The next full vector scores correctly.
